// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Arithmetic, logic, compare and undefined opcodes finish in one cycle.
// Shifts by n > 0 move one bit per cycle through a working register.
// Results and flags are registered, and they stay stable in HOLD until consumed.
module alu_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_operandA,
    input  logic [DATA_WIDTH-1:0] i_operandB,
    input  logic [3:0]            i_opcode,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_negative,
    output logic                  o_exception,
    output logic                  o_busy
);

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_OR  = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;
    localparam logic [3:0] OP_NOR = 4'b1111;
    localparam logic [3:0] OP_SLT = 4'b1011;
    localparam logic [3:0] OP_SRA = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    carry_q, carry_d;
    logic                    ovf_q, ovf_d;
    logic                    neg_q, neg_d;
    logic                    exc_q, exc_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [SHAMT_WIDTH-1:0]  shamt_s;
    logic                    is_shift_s;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   alu_res_s;
    logic                    alu_c_s;
    logic                    alu_v_s;
    logic                    alu_x_s;
    logic [DATA_WIDTH-1:0]   step_res_s;
    logic                    step_c_s;

    // ready_q is only ever set when the next state is IDLE, so it also gates acceptance
    // in the first cycle after reset release.
    assign accept_s   = i_valid && ready_q;
    assign sum_s      = {1'b0, i_operandA} + {1'b0, i_operandB};
    assign diff_s     = {1'b0, i_operandA} - {1'b0, i_operandB};
    assign shamt_s    = i_operandB[SHAMT_WIDTH-1:0];
    assign is_shift_s = (i_opcode == OP_SRA) || (i_opcode == OP_SRL) || (i_opcode == OP_SLL);

    // Compute the single-cycle result and flags from the live request inputs.
    always_comb begin
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_x_s   = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                alu_res_s = sum_s[DATA_WIDTH-1:0];
                alu_c_s   = sum_s[DATA_WIDTH];
                alu_v_s   = (i_operandA[DATA_WIDTH-1] == i_operandB[DATA_WIDTH-1]) &&
                            (sum_s[DATA_WIDTH-1] != i_operandA[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[DATA_WIDTH-1:0];
                alu_c_s   = diff_s[DATA_WIDTH];
                alu_v_s   = (i_operandA[DATA_WIDTH-1] != i_operandB[DATA_WIDTH-1]) &&
                            (diff_s[DATA_WIDTH-1] != i_operandA[DATA_WIDTH-1]);
            end
            OP_AND: alu_res_s = i_operandA & i_operandB;
            OP_OR:  alu_res_s = i_operandA | i_operandB;
            OP_XOR: alu_res_s = i_operandA ^ i_operandB;
            OP_NOR: alu_res_s = ~(i_operandA | i_operandB);
            OP_SLT: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_operandA) < $signed(i_operandB))};
            // Shifts only finish here when the amount is zero: the result is A, with no carry.
            OP_SRA, OP_SRL, OP_SLL: alu_res_s = i_operandA;
            default: alu_x_s = 1'b1;
        endcase
    end

    // Shift the working register by one bit and capture the bit that falls out.
    always_comb begin
        step_res_s = work_q;
        step_c_s   = 1'b0;
        case (op_q)
            OP_SRA: begin
                step_res_s = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
                step_c_s   = work_q[0];
            end
            OP_SRL: begin
                step_res_s = {1'b0, work_q[DATA_WIDTH-1:1]};
                step_c_s   = work_q[0];
            end
            OP_SLL: begin
                step_res_s = {work_q[DATA_WIDTH-2:0], 1'b0};
                step_c_s   = work_q[DATA_WIDTH-1];
            end
            default: begin
                step_res_s = work_q;
                step_c_s   = 1'b0;
            end
        endcase
    end

    // Compute the next state, the shift datapath and the result/flag updates.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        exc_d    = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_shift_s && (shamt_s != '0)) begin
                    work_d  = i_operandA;
                    op_d    = i_opcode;
                    cnt_d   = shamt_s;
                    state_d = ST_SHIFT;
                end else if (accept_s) begin
                    result_d = alu_res_s;
                    zero_d   = (alu_res_s == '0);
                    neg_d    = alu_res_s[DATA_WIDTH-1];
                    carry_d  = alu_c_s;
                    ovf_d    = alu_v_s;
                    exc_d    = alu_x_s;
                    state_d  = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = step_res_s;
                cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d = step_res_s;
                    zero_d   = (step_res_s == '0);
                    neg_d    = step_res_s[DATA_WIDTH-1];
                    carry_d  = step_c_s;
                    ovf_d    = 1'b0;
                    exc_d    = 1'b0;
                    state_d  = ST_HOLD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    // Update all state and registered outputs; reset clears everything at once.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= 4'b0000;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            exc_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            exc_q    <= exc_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_result    = result_q;
    assign o_zero      = zero_q;
    assign o_carry     = carry_q;
    assign o_overflow  = ovf_q;
    assign o_negative  = neg_q;
    assign o_exception = exc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (DATA_WIDTH 8).
// Each task drives one scenario and compares outputs against hand-computed values.
// Flag vectors are packed as {zero, carry, overflow, negative, exception}.
module tb_alu_pipe;

    logic       i_clock;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_operandA;
    logic [7:0] i_operandB;
    logic [3:0] i_opcode;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic       o_zero;
    logic       o_carry;
    logic       o_overflow;
    logic       o_negative;
    logic       o_exception;
    logic       o_busy;

    int pass_cnt;
    int total_cnt;

    alu_pipe #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_operandA(i_operandA), .i_operandB(i_operandB), .i_opcode(i_opcode),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_zero(o_zero), .o_carry(o_carry), .o_overflow(o_overflow),
        .o_negative(o_negative), .o_exception(o_exception), .o_busy(o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Stimulus only: issue one request (called #1 after an edge with o_ready high).
    // The result is the number of edges, counting the accept edge, until o_valid is seen.
    // When keep is set, i_valid stays high with junk operands to show they are ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input bit keep, output int lat);
        i_operandA = a; i_operandB = b; i_opcode = op; i_valid = 1'b1;
        @(posedge i_clock); #1;
        if (keep) begin
            i_operandA = 8'h77; i_operandB = 8'h11; i_opcode = 4'b1000;
        end else begin
            i_valid = 1'b0;
        end
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge i_clock); #1;
            lat++;
        end
        i_valid = 1'b0;
    endtask

    // Stimulus only: consume the held result and return to IDLE.
    task automatic release_op();
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready} !== 16'h0000)
            $display("FAIL reset_outputs: got %h %b%b%b%b%b v%b b%b r%b, want all zero",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready);
        else pass_cnt++;
        i_reset = 1'b0;
        #1;
        total_cnt++;
        if (o_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", o_ready);
        else pass_cnt++;
        @(posedge i_clock); #1;
        total_cnt++;
        if ({o_ready, o_valid, o_busy} !== 3'b100)
            $display("FAIL ready_after_release: got r%b v%b b%b want r1 v0 b0", o_ready, o_valid, o_busy);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        int lat;
        run_op(8'h7F, 8'h01, 4'b1000, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'h80, 5'b00110})
            $display("FAIL add_7f_01: got %h %b%b%b%b%b want 80 00110", o_result, o_zero, o_carry, o_overflow, o_negative, o_exception);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
        else pass_cnt++;
        release_op();
        run_op(8'hFF, 8'h01, 4'b1000, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'h00, 5'b11000})
            $display("FAIL add_ff_01: got %h %b%b%b%b%b want 00 11000", o_result, o_zero, o_carry, o_overflow, o_negative, o_exception);
        else pass_cnt++;
        release_op();
        run_op(8'h00, 8'h01, 4'b1010, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'hFF, 5'b01010})
            $display("FAIL sub_00_01: got %h %b%b%b%b%b want ff 01010", o_result, o_zero, o_carry, o_overflow, o_negative, o_exception);
        else pass_cnt++;
        release_op();
        run_op(8'h80, 8'h01, 4'b1010, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'h7F, 5'b00100})
            $display("FAIL sub_80_01: got %h %b%b%b%b%b want 7f 00100", o_result, o_zero, o_carry, o_overflow, o_negative, o_exception);
        else pass_cnt++;
        release_op();
    endtask

    task automatic test_logic_slt();
        logic [7:0]  va [7] = '{8'hF0, 8'hF0, 8'hFF, 8'hF0, 8'hFF, 8'h01, 8'h80};
        logic [7:0]  vb [7] = '{8'h3C, 8'h0C, 8'h0F, 8'h0F, 8'h01, 8'hFF, 8'h7F};
        logic [3:0]  vo [7] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1011, 4'b1011, 4'b1011};
        logic [12:0] ve [7] = '{{8'h30, 5'b00000}, {8'hFC, 5'b00010}, {8'hF0, 5'b00010},
                                {8'h00, 5'b10000}, {8'h01, 5'b00000}, {8'h00, 5'b10000},
                                {8'h01, 5'b00000}};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vo[i], 1'b0, lat);
            total_cnt++;
            if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== ve[i] || lat !== 1)
                $display("FAIL logic_slt_%0d: got %h %b%b%b%b%b lat %0d want %h lat 1", i,
                         o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, lat, ve[i]);
            else pass_cnt++;
            release_op();
        end
    endtask

    task automatic test_shift();
        logic [7:0]  va [6] = '{8'h80, 8'h0F, 8'h81, 8'h85, 8'h81, 8'h01};
        logic [7:0]  vb [6] = '{8'h03, 8'h02, 8'h01, 8'hF8, 8'h11, 8'h07};
        logic [3:0]  vo [6] = '{4'b0011, 4'b0010, 4'b0000, 4'b0011, 4'b0011, 4'b0000};
        logic [12:0] ve [6] = '{{8'hF0, 5'b00010}, {8'h03, 5'b01000}, {8'h02, 5'b01000},
                                {8'h85, 5'b00010}, {8'hC0, 5'b01010}, {8'h80, 5'b00010}};
        int          vl [6] = '{4, 3, 2, 1, 2, 8};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vo[i], (i == 1), lat);
            total_cnt++;
            if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== ve[i])
                $display("FAIL shift_result_%0d: got %h %b%b%b%b%b want %h", i,
                         o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, ve[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat !== vl[i]) $display("FAIL shift_latency_%0d: got %0d want %0d", i, lat, vl[i]);
            else pass_cnt++;
            release_op();
        end
    endtask

    task automatic test_undefined();
        int lat;
        run_op(8'h12, 8'h34, 4'b0101, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'h00, 5'b10001} || lat !== 1)
            $display("FAIL undef_0101: got %h %b%b%b%b%b lat %0d want 00 10001 lat 1",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, lat);
        else pass_cnt++;
        release_op();
        run_op(8'hFF, 8'hFF, 4'b1001, 1'b0, lat);
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception} !== {8'h00, 5'b10001})
            $display("FAIL undef_1001: got %h %b%b%b%b%b want 00 10001",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception);
        else pass_cnt++;
        release_op();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(8'h05, 8'h03, 4'b1000, 1'b0, lat);
        // New request presented during HOLD must be ignored until IDLE.
        i_valid = 1'b1; i_operandA = 8'h55; i_operandB = 8'h55; i_opcode = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_ready} !== {8'h08, 5'b00000, 2'b10})
                $display("FAIL hold_cycle_%0d: got %h %b%b%b%b%b v%b r%b want 08 00000 v1 r0", c,
                         o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_ready);
            else pass_cnt++;
            @(posedge i_clock); #1;
        end
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
        total_cnt++;
        if ({o_valid, o_ready, o_busy} !== 3'b010)
            $display("FAIL hold_release: got v%b r%b b%b want v0 r1 b0", o_valid, o_ready, o_busy);
        else pass_cnt++;
        // i_valid is still high: the waiting request is accepted on this edge.
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid} !== {8'hAA, 5'b00110, 1'b1})
            $display("FAIL b2b_add_55_55: got %h %b%b%b%b%b v%b want aa 00110 v1",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid);
        else pass_cnt++;
        release_op();
    endtask

    task automatic test_reset_mid();
        bit seen;
        i_operandA = 8'h01; i_operandB = 8'h07; i_opcode = 4'b0000; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        total_cnt++;
        if ({o_busy, o_valid} !== 2'b10) $display("FAIL shift_busy: got b%b v%b want b1 v0", o_busy, o_valid);
        else pass_cnt++;
        i_reset = 1'b1;
        #1;
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready} !== 16'h0000)
            $display("FAIL reset_in_shift: got %h %b%b%b%b%b v%b b%b r%b want all zero",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready);
        else pass_cnt++;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge i_clock); #1;
            if (o_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0 || o_ready !== 1'b1)
            $display("FAIL no_valid_after_reset: seen %b ready %b want seen 0 ready 1", seen, o_ready);
        else pass_cnt++;
        // Reset while a result is held in HOLD.
        i_operandA = 8'h7F; i_operandB = 8'h01; i_opcode = 4'b1000; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        total_cnt++;
        if ({o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready} !== 16'h0000)
            $display("FAIL reset_in_hold: got %h %b%b%b%b%b v%b b%b r%b want all zero",
                     o_result, o_zero, o_carry, o_overflow, o_negative, o_exception, o_valid, o_busy, o_ready);
        else pass_cnt++;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        total_cnt++;
        if ({o_valid, o_ready} !== 2'b01) $display("FAIL hold_reset_recover: got v%b r%b want v0 r1", o_valid, o_ready);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_operandA = 8'h00; i_operandB = 8'h00; i_opcode = 4'b0000;
        test_reset();
        test_arith();
        test_logic_slt();
        test_shift();
        test_undefined();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
